pio_cmd_bridge: RTL and testbench

FPGA-side command decoder that sits directly behind the HPS PIO pair. It consumes the 32-bit command word the HPS drives out on the "saida" PIO and produces the 32-bit status word the HPS reads back on the "entrada" PIO. It translates toggle-handshaked HPS commands into image-buffer writes, result-buffer reads and edge-filter start/mode control. It runs in the clk_clk domain, the same domain as the PIOs, so no CDC is needed.

---
 rtl/pio_cmd_bridge_pkg.sv | 33 +++
 rtl/pio_cmd_bridge.sv | 129 ++++++++++++
 tb/tb_pio_cmd_bridge.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pio_cmd_bridge_pkg.sv
// Shared encodings for the HPS PIO command bridge: opcodes, FSM states and
// bit positions inside the command and status words.
package pio_bridge_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_WRITE    = 3'd1,
    OP_READ     = 3'd2,
    OP_START    = 3'd3,
    OP_SET_MODE = 3'd4,
    OP_CLEAR    = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_ACK
  } state_e;

  localparam int REQ_BIT  = 31;
  localparam int OP_MSB   = 30;
  localparam int OP_LSB   = 28;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam int ACK_BIT  = 31;
  localparam int BUSY_BIT = 30;
  localparam int DONE_BIT = 29;
  localparam int ERR_BIT  = 28;

endpackage

// File: rtl/pio_cmd_bridge.sv
// Decodes toggle-handshaked HPS PIO commands into image writes, result reads
// and edge-filter control; returns ack/busy/done/err/read-data on the status PIO.
module pio_cmd_bridge
  import pio_bridge_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int NPIX   = 76800,
  parameter int RD_LAT = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       pio_cmd,
  output logic [31:0]       pio_status,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              res_re,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_rdata,
  output logic              filt_start,
  output logic [1:0]        filt_mode,
  input  logic              filt_busy,
  input  logic              filt_done
);

  localparam logic [2:0]      WAIT_LAST = 3'(RD_LAT - 1);
  localparam logic [ADDR_W:0] NPIX_W    = (ADDR_W+1)'(NPIX);

  state_e            state, state_nx;
  logic [31:0]       cmd_q;
  logic              ack_q, req_q, err_q, err_st, done_q, start_pend, busy;
  logic [2:0]        op_q, wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q, rdata_q, stat_data;
  logic              addr_ok, err_c, clr_done, mode_we;
  logic              unused_cmd;

  assign unused_cmd = ^cmd_q;
  assign busy       = filt_busy | start_pend;
  assign addr_ok    = ({1'b0, addr_q} < NPIX_W);
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign res_addr   = addr_q;
  assign pio_status = {ack_q, busy, done_q, err_st, 20'b0, stat_data};

  always_comb begin
    state_nx   = state;
    err_c      = 1'b0;
    mem_we     = 1'b0;
    res_re     = 1'b0;
    filt_start = 1'b0;
    mode_we    = 1'b0;
    clr_done   = 1'b0;
    case (state)
      S_IDLE: if (cmd_q[REQ_BIT] != ack_q) state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_ACK;
        case (op_q)
          OP_NOP:      ;
          OP_WRITE:    if (addr_ok && !busy) mem_we = 1'b1; else err_c = 1'b1;
          OP_READ:     if (addr_ok && !busy) begin
                         res_re   = 1'b1;
                         state_nx = S_WAIT;
                       end else err_c = 1'b1;
          OP_START:    if (!busy) begin
                         filt_start = 1'b1;
                         clr_done   = 1'b1;
                       end else err_c = 1'b1;
          OP_SET_MODE: if (!busy) mode_we = 1'b1; else err_c = 1'b1;
          OP_CLEAR:    clr_done = 1'b1;
          default:     err_c = 1'b1;
        endcase
      end
      S_WAIT: if (wcnt == WAIT_LAST) state_nx = S_ACK;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      ack_q      <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      err_st     <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      stat_data  <= '0;
      wcnt       <= '0;
      start_pend <= 1'b0;
      done_q     <= 1'b0;
      filt_mode  <= '0;
    end else begin
      state <= state_nx;
      cmd_q <= pio_cmd;
      // Fields are frozen here so pio_cmd may change freely until ACK.
      if (state == S_IDLE && state_nx == S_EXEC) begin
        req_q  <= cmd_q[REQ_BIT];
        op_q   <= cmd_q[OP_MSB:OP_LSB];
        addr_q <= cmd_q[ADDR_LSB+ADDR_W-1:ADDR_LSB];
        data_q <= cmd_q[DATA_MSB:DATA_LSB];
      end
      if (state == S_EXEC) begin
        err_q <= err_c;
        wcnt  <= '0;
      end
      if (state == S_WAIT) begin
        wcnt <= wcnt + 3'd1;
        if (wcnt == WAIT_LAST) rdata_q <= res_rdata;
      end
      if (state == S_ACK) begin
        ack_q     <= req_q;
        err_st    <= err_q;
        stat_data <= rdata_q;
      end
      // start_pend bridges the gap until the filter raises busy.
      if (filt_start)                  start_pend <= 1'b1;
      else if (filt_busy || filt_done) start_pend <= 1'b0;
      if (filt_done)     done_q <= 1'b1;
      else if (clr_done) done_q <= 1'b0;
      if (mode_we) filt_mode <= data_q[1:0];
    end
  end

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// Directed bench for pio_cmd_bridge: handshake latency, strobes, busy/done
// tracking, error paths and reset during a read.
module tb_pio_cmd_bridge;
  import pio_bridge_pkg::*;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] pio_cmd, pio_status;
  logic        mem_we, res_re, filt_start, filt_busy, filt_done;
  logic [16:0] mem_addr, res_addr;
  logic [7:0]  mem_wdata, res_rdata;
  logic [1:0]  filt_mode;

  pio_cmd_bridge #(.ADDR_W(17), .NPIX(76800), .RD_LAT(2)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .pio_cmd(pio_cmd), .pio_status(pio_status),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .res_re(res_re), .res_addr(res_addr), .res_rdata(res_rdata),
    .filt_start(filt_start), .filt_mode(filt_mode),
    .filt_busy(filt_busy), .filt_done(filt_done)
  );

  always #5 clk_clk = ~clk_clk;

  // Result RAM: two-cycle latency, junk on idle cycles to expose timing slips.
  logic [7:0] rd1, rd2;
  always @(posedge clk_clk) begin
    rd1 <= res_re ? ((res_addr == 17'd76799) ? 8'h3C : res_addr[7:0]) : 8'hEE;
    rd2 <= rd1;
  end
  assign res_rdata = rd2;

  int n_chk = 0, n_err = 0;
  int we_cnt, re_cnt, st_cnt;
  logic [16:0] we_addr;
  logic [7:0]  we_data;
  logic        tgl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Drive one command (caller has set tgl) and watch the ack land on edge +lat.
  task automatic do_cmd(input logic [2:0] op, input logic [16:0] addr,
                        input logic [7:0] data, input int lat, input int done_at);
    we_cnt = 0; re_cnt = 0; st_cnt = 0;
    pio_cmd = {tgl, op, 3'b0, addr, data};
    for (int k = 1; k <= lat; k++) begin
      step();
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (res_re) re_cnt++;
      if (filt_start) st_cnt++;
      if (k == lat - 1) chk("ack_early", {31'b0, pio_status[ACK_BIT]}, {31'b0, ~tgl});
      if (k == lat)     chk("ack_edge",  {31'b0, pio_status[ACK_BIT]}, {31'b0, tgl});
      filt_done = (k == done_at);
    end
  endtask

  initial begin
    reset_reset_n = 1'b0;
    pio_cmd = '0; filt_busy = 1'b0; filt_done = 1'b0;
    repeat (3) step();
    chk("rst_status", pio_status, 32'h0);
    chk("rst_strobes", {29'b0, mem_we, res_re, filt_start}, 32'h0);
    chk("rst_mode", {30'b0, filt_mode}, 32'h0);
    reset_reset_n = 1'b1;
    repeat (2) step();
    chk("idle_no_ack", {31'b0, pio_status[ACK_BIT]}, 32'h0);

    tgl = ~tgl; do_cmd(OP_WRITE, 17'd5, 8'hA7, 4, 0);
    chk("wr_we_cnt", we_cnt, 1);
    chk("wr_addr", {15'b0, we_addr}, 32'd5);
    chk("wr_data", {24'b0, we_data}, 32'hA7);
    chk("wr_err", {31'b0, pio_status[ERR_BIT]}, 32'h0);

    tgl = ~tgl; do_cmd(OP_READ, 17'd76799, 8'h00, 6, 0);
    chk("rd_re_cnt", re_cnt, 1);
    chk("rd_data", {24'b0, pio_status[7:0]}, 32'h3C);
    chk("rd_err", {31'b0, pio_status[ERR_BIT]}, 32'h0);

    tgl = ~tgl; do_cmd(OP_WRITE, 17'd76800, 8'h11, 4, 0);
    chk("wr_oob_we", we_cnt, 0);
    chk("wr_oob_err", {31'b0, pio_status[ERR_BIT]}, 32'h1);
    tgl = ~tgl; do_cmd(OP_NOP, 17'd0, 8'h00, 4, 0);
    chk("nop_err", {31'b0, pio_status[ERR_BIT]}, 32'h0);
    chk("nop_keeps_data", {24'b0, pio_status[7:0]}, 32'h3C);

    tgl = ~tgl; do_cmd(OP_READ, 17'd76800, 8'h00, 4, 0);
    chk("rd_oob_re", re_cnt, 0);
    chk("rd_oob_err", {31'b0, pio_status[ERR_BIT]}, 32'h1);

    tgl = ~tgl; do_cmd(OP_SET_MODE, 17'd0, 8'h02, 4, 0);
    chk("mode_set", {30'b0, filt_mode}, 32'd2);
    chk("mode_err", {31'b0, pio_status[ERR_BIT]}, 32'h0);

    tgl = ~tgl; do_cmd(OP_START, 17'd0, 8'h00, 4, 0);
    chk("start_pulse", st_cnt, 1);
    chk("start_err", {31'b0, pio_status[ERR_BIT]}, 32'h0);
    chk("start_pend_busy", {31'b0, pio_status[BUSY_BIT]}, 32'h1);

    filt_busy = 1'b1;
    tgl = ~tgl; do_cmd(OP_WRITE, 17'd7, 8'h55, 4, 0);
    chk("busy_wr_we", we_cnt, 0);
    chk("busy_wr_err", {31'b0, pio_status[ERR_BIT]}, 32'h1);
    tgl = ~tgl; do_cmd(OP_SET_MODE, 17'd0, 8'h03, 4, 0);
    chk("busy_mode_err", {31'b0, pio_status[ERR_BIT]}, 32'h1);
    chk("busy_mode_kept", {30'b0, filt_mode}, 32'd2);
    chk("busy_flag", {31'b0, pio_status[BUSY_BIT]}, 32'h1);
    chk("busy_no_done", {31'b0, pio_status[DONE_BIT]}, 32'h0);
    repeat (2) step();
    filt_busy = 1'b0; filt_done = 1'b1;
    step();
    filt_done = 1'b0;
    chk("done_set", {31'b0, pio_status[DONE_BIT]}, 32'h1);
    chk("busy_clear", {31'b0, pio_status[BUSY_BIT]}, 32'h0);

    tgl = ~tgl; do_cmd(OP_CLEAR, 17'd0, 8'h00, 4, 0);
    chk("clear_done", {31'b0, pio_status[DONE_BIT]}, 32'h0);

    // CLEAR lands in EXEC on the same edge as filt_done: set must win.
    tgl = ~tgl; do_cmd(OP_CLEAR, 17'd0, 8'h00, 4, 2);
    chk("done_set_wins", {31'b0, pio_status[DONE_BIT]}, 32'h1);

    tgl = ~tgl; do_cmd(3'd7, 17'd3, 8'h01, 4, 0);
    chk("ill_err", {31'b0, pio_status[ERR_BIT]}, 32'h1);
    chk("ill_strobes", we_cnt + re_cnt + st_cnt, 0);

    // Reset while the FSM sits in WAIT.
    tgl = ~tgl;
    pio_cmd = {tgl, OP_READ, 3'b0, 17'd100, 8'h00};
    repeat (3) step();
    reset_reset_n = 1'b0;
    #1;
    chk("midrd_status", pio_status, 32'h0);
    chk("midrd_strobes", {29'b0, mem_we, res_re, filt_start}, 32'h0);
    chk("midrd_mode", {30'b0, filt_mode}, 32'h0);
    step();
    reset_reset_n = 1'b1;
    tgl = 1'b1; do_cmd(OP_READ, 17'd100, 8'h00, 6, 0);
    chk("reexec_re", re_cnt, 1);
    chk("reexec_data", {24'b0, pio_status[7:0]}, 32'h64);
    chk("reexec_err", {31'b0, pio_status[ERR_BIT]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
